// File: rtl/hsid_x_fetch_sched.sv
// OBI read scheduler: fetches the captured spectrum and then every library pixel,
// and streams the packed band words out in order with position tags.
module hsid_x_fetch_sched #(
  parameter int WORD_WIDTH        = 32,
  parameter int HSP_BANDS_WIDTH   = 9,
  parameter int HSP_LIBRARY_WIDTH = 9,
  parameter int MAX_OUTSTANDING   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  input  logic                         clear_i,
  input  logic [WORD_WIDTH-1:0]        captured_addr_i,
  input  logic [WORD_WIDTH-1:0]        library_addr_i,
  input  logic [HSP_BANDS_WIDTH-1:0]   bands_i,
  input  logic [HSP_LIBRARY_WIDTH-1:0] library_size_i,
  output logic                         obi_req_o,
  output logic [WORD_WIDTH-1:0]        obi_addr_o,
  output logic                         obi_we_o,
  input  logic                         obi_gnt_i,
  input  logic                         obi_rvalid_i,
  input  logic [WORD_WIDTH-1:0]        obi_rdata_i,
  output logic                         data_valid_o,
  input  logic                         data_ready_i,
  output logic [WORD_WIDTH-1:0]        data_o,
  output logic                         is_captured_o,
  output logic                         last_pack_o,
  output logic                         last_pixel_o,
  output logic [HSP_LIBRARY_WIDTH-1:0] pixel_idx_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         error_o
);

  localparam int WW = WORD_WIDTH;
  localparam int BW = HSP_BANDS_WIDTH;
  localparam int LW = HSP_LIBRARY_WIDTH;
  localparam int TW = BW + LW;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic [2:0] {IDLE, CAPT, LIB, DRAIN, DONE} state_t;

  state_t          state;
  logic [WW-1:0]   lib_addr_q;
  logic [WW-1:0]   addr_q;
  logic [BW-1:0]   packs_q;
  logic [LW-1:0]   size_q;
  logic [TW-1:0]   issue_left_q;
  logic            req_q;
  logic            stale_q;
  logic            busy_q;
  logic            done_q;
  logic            err_q;
  logic [CW-1:0]   outst_q;
  logic [CW-1:0]   drop_q;
  logic [CW-1:0]   cnt_q;
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [BW-1:0]   capt_left_q;
  logic [BW-1:0]   pack_idx_q;
  logic [LW-1:0]   pix_idx_q;
  logic [WW-1:0]   mem [MAX_OUTSTANDING];

  logic [BW:0]     packs_sum;
  logic [BW-1:0]   packs_w;
  logic [TW-1:0]   lib_total;
  logic            fire;
  logic            fire_live;
  logic            rv_ok;
  logic            push;
  logic            pop;
  logic            cfg_ok;
  logic            start_ok;
  logic            issue_more;
  logic            credit;
  logic            in_capt;
  logic            pix_end;
  logic [CW:0]     out_next;
  logic [CW:0]     cnt_next;
  logic [CW:0]     drop_next;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  assign packs_sum = ({1'b0, bands_i} + (BW+1)'(1)) >> 1;
  assign packs_w   = packs_sum[BW-1:0];
  assign lib_total = TW'(library_size_i) * TW'(packs_w);

  // A request still held across a clear is stale: its grant must not advance the new job.
  assign fire      = req_q & obi_gnt_i;
  assign fire_live = fire & ~stale_q;
  assign rv_ok     = obi_rvalid_i & (outst_q != '0);
  assign push      = rv_ok & (drop_q == '0) & ~clear_i;
  assign pop       = (cnt_q != '0) & data_ready_i;
  assign cfg_ok    = (bands_i != '0) & (library_size_i != '0);
  assign start_ok  = start_i & (state == IDLE) & ~clear_i & (~req_q | fire);

  assign out_next  = {1'b0, outst_q} + (CW+1)'(fire) - (CW+1)'(rv_ok);
  assign cnt_next  = {1'b0, cnt_q} + (CW+1)'(push) - (CW+1)'(pop);
  assign drop_next = {1'b0, drop_q} + (CW+1)'(fire & stale_q)
                   - (CW+1)'(rv_ok & (drop_q != '0));
  assign credit    = ({1'b0, out_next} + {1'b0, cnt_next}) < (CW+2)'(MAX_OUTSTANDING);
  assign issue_more = ~clear_i & ((start_ok & cfg_ok) | (state == CAPT) |
                      ((state == LIB) & ~(fire_live & (issue_left_q == TW'(1)))));

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      lib_addr_q   <= '0;
      addr_q       <= '0;
      packs_q      <= '0;
      size_q       <= '0;
      issue_left_q <= '0;
      req_q        <= 1'b0;
      stale_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      outst_q      <= '0;
      drop_q       <= '0;
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      capt_left_q  <= '0;
      pack_idx_q   <= '0;
      pix_idx_q    <= '0;
    end else begin
      req_q   <= (req_q & ~fire) | (issue_more & credit);
      outst_q <= out_next[CW-1:0];
      cnt_q   <= cnt_next[CW-1:0];
      drop_q  <= drop_next[CW-1:0];
      done_q  <= 1'b0;
      if (fire) stale_q <= 1'b0;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (obi_rvalid_i && outst_q == '0) err_q <= 1'b1;

      if (pop) begin
        if (in_capt) begin
          capt_left_q <= capt_left_q - BW'(1);
        end else if (pix_end) begin
          pack_idx_q <= '0;
          pix_idx_q  <= pix_idx_q + LW'(1);
        end else begin
          pack_idx_q <= pack_idx_q + BW'(1);
        end
      end

      if (clear_i) begin
        // Everything in flight now belongs to the aborted job and is dropped on return.
        state       <= IDLE;
        busy_q      <= 1'b0;
        cnt_q       <= '0;
        wr_ptr_q    <= '0;
        rd_ptr_q    <= '0;
        drop_q      <= out_next[CW-1:0];
        stale_q     <= req_q & ~fire;
        capt_left_q <= '0;
        pack_idx_q  <= '0;
        pix_idx_q   <= '0;
      end else begin
        case (state)
          IDLE: if (start_ok) begin
            lib_addr_q   <= library_addr_i;
            packs_q      <= packs_w;
            size_q       <= library_size_i;
            addr_q       <= captured_addr_i;
            issue_left_q <= TW'(packs_w);
            capt_left_q  <= packs_w;
            pack_idx_q   <= '0;
            pix_idx_q    <= '0;
            err_q        <= ~cfg_ok;
            if (cfg_ok) begin
              state  <= CAPT;
              busy_q <= 1'b1;
            end else begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
          CAPT: if (fire_live) begin
            if (issue_left_q == TW'(1)) begin
              state        <= LIB;
              addr_q       <= lib_addr_q;
              issue_left_q <= lib_total_q();
            end else begin
              addr_q       <= addr_q + WW'(4);
              issue_left_q <= issue_left_q - TW'(1);
            end
          end
          LIB: if (fire_live) begin
            addr_q       <= addr_q + WW'(4);
            issue_left_q <= issue_left_q - TW'(1);
            if (issue_left_q == TW'(1)) state <= DRAIN;
          end
          DRAIN: if (outst_q == '0 && cnt_q == '0) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  function automatic logic [TW-1:0] lib_total_q();
    return TW'(size_q) * TW'(packs_q);
  endfunction

  // NOTE: the response buffer is not reset; the count and pointers alone decide
  // which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= obi_rdata_i;
  end

  assign in_capt = capt_left_q != '0;
  assign pix_end = pack_idx_q == packs_q - BW'(1);

  assign obi_req_o     = req_q;
  assign obi_addr_o    = addr_q;
  assign obi_we_o      = 1'b0;
  assign data_valid_o  = cnt_q != '0;
  assign data_o        = data_valid_o ? mem[rd_ptr_q] : '0;
  assign is_captured_o = data_valid_o & in_capt;
  assign last_pack_o   = data_valid_o & (in_capt ? (capt_left_q == BW'(1)) : pix_end);
  assign last_pixel_o  = data_valid_o & ~in_capt & pix_end & (pix_idx_q == size_q - LW'(1));
  assign pixel_idx_o   = (data_valid_o & ~in_capt) ? pix_idx_q : '0;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign error_o       = err_q;

  unused_lib_total: assert property (@(posedge clk) disable iff (rst) 1'b1 || (lib_total != '0));

endmodule

// File: tb/tb_hsid_x_fetch_sched.sv
// Directed bench: OBI slave model with configurable grant/latency, expected stream built
// from the job parameters, plus stall, clear, reset and bad-config cases.
module tb_hsid_x_fetch_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, clear_i;
  logic [31:0] captured_addr_i, library_addr_i;
  logic [8:0]  bands_i, library_size_i;
  logic        obi_req_o, obi_we_o, obi_gnt_i, obi_rvalid_i;
  logic [31:0] obi_addr_o, obi_rdata_i;
  logic        data_valid_o, data_ready_i, is_captured_o, last_pack_o, last_pixel_o;
  logic [31:0] data_o;
  logic [8:0]  pixel_idx_o;
  logic        busy_o, done_o, error_o;

  always #5 clk = ~clk;

  hsid_x_fetch_sched dut (
    .clk(clk), .rst(rst), .start_i(start_i), .clear_i(clear_i),
    .captured_addr_i(captured_addr_i), .library_addr_i(library_addr_i),
    .bands_i(bands_i), .library_size_i(library_size_i),
    .obi_req_o(obi_req_o), .obi_addr_o(obi_addr_o), .obi_we_o(obi_we_o),
    .obi_gnt_i(obi_gnt_i), .obi_rvalid_i(obi_rvalid_i), .obi_rdata_i(obi_rdata_i),
    .data_valid_o(data_valid_o), .data_ready_i(data_ready_i), .data_o(data_o),
    .is_captured_o(is_captured_o), .last_pack_o(last_pack_o), .last_pixel_o(last_pixel_o),
    .pixel_idx_o(pixel_idx_o), .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
  endfunction

  logic [31:0] exp_addr[$];
  logic [11:0] exp_tag[$];
  logic [31:0] rq_addr[$];
  int          rq_dly[$];
  int gnt_mode, lat_min, lat_max, stall_at, stall_left;
  int n_req, n_pop, n_rv, n_done, n_valid, n_reqcyc, max_inflight;
  int watch_idx, last_pixel_at;
  logic [31:0] watch_addr, last_req_addr, held_addr;
  logic        held_req;

  // One bus cycle: observe at the falling edge, then drive for the next rising edge.
  task automatic step();
    @(negedge clk);
    if (done_o) n_done++;
    if (data_valid_o) n_valid++;
    if (obi_req_o) n_reqcyc++;
    if (held_req) begin
      check("req_hold", obi_req_o, 1);
      check("addr_hold", obi_addr_o, held_addr);
    end
    if (stall_left > 0) begin
      data_ready_i = 1'b0;
      stall_left--;
    end else if (stall_at >= 0 && n_pop == stall_at) begin
      data_ready_i = 1'b0;
      stall_left = 19;
      stall_at = -1;
    end else begin
      data_ready_i = 1'b1;
    end
    obi_gnt_i = (gnt_mode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
    if (data_valid_o && data_ready_i) begin
      if (n_pop < exp_tag.size()) begin
        check("data", data_o, mem_word(exp_addr[n_pop]));
        check("tags", {is_captured_o, last_pack_o, last_pixel_o, pixel_idx_o}, exp_tag[n_pop]);
      end else begin
        check("extra_word", data_o, 0);
        check("extra_word_cnt", n_pop, exp_tag.size());
      end
      if (last_pixel_o) last_pixel_at = n_pop;
      n_pop++;
    end
    if (rq_addr.size() > 0 && rq_dly[0] <= 0) begin
      obi_rvalid_i = 1'b1;
      obi_rdata_i  = mem_word(rq_addr.pop_front());
      void'(rq_dly.pop_front());
      n_rv++;
    end else begin
      obi_rvalid_i = 1'b0;
      obi_rdata_i  = '0;
    end
    foreach (rq_dly[i]) rq_dly[i]--;
    held_req = 1'b0;
    if (obi_req_o && obi_gnt_i) begin
      if (n_req < exp_addr.size()) check("req_addr", obi_addr_o, exp_addr[n_req]);
      else check("extra_req", n_req, exp_addr.size());
      if (n_req == watch_idx) watch_addr = obi_addr_o;
      last_req_addr = obi_addr_o;
      rq_addr.push_back(obi_addr_o);
      rq_dly.push_back($urandom_range(lat_max, lat_min));
      n_req++;
    end else if (obi_req_o) begin
      held_req  = 1'b1;
      held_addr = obi_addr_o;
    end
    if (n_req - n_pop > max_inflight) max_inflight = n_req - n_pop;
  endtask

  task automatic setup(input logic [31:0] ca, input logic [31:0] la, input int bands, input int size);
    int packs;
    exp_addr.delete();
    exp_tag.delete();
    packs = (bands + 1) / 2;
    if (bands != 0 && size != 0) begin
      for (int k = 0; k < packs; k++) begin
        exp_addr.push_back(ca + 32'(4 * k));
        exp_tag.push_back({1'b1, k == packs - 1, 1'b0, 9'd0});
      end
      for (int j = 0; j < size; j++)
        for (int k = 0; k < packs; k++) begin
          exp_addr.push_back(la + 32'(4 * (packs * j + k)));
          exp_tag.push_back({1'b0, k == packs - 1, (j == size - 1) && (k == packs - 1), 9'(j)});
        end
    end
    n_req = 0; n_pop = 0; n_rv = 0; n_done = 0; n_valid = 0; n_reqcyc = 0;
    max_inflight = 0; last_pixel_at = -1; watch_addr = '0;
    captured_addr_i = ca;
    library_addr_i  = la;
    bands_i         = 9'(bands);
    library_size_i  = 9'(size);
  endtask

  task automatic launch();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    // Scrambled after the start: the latched job must not notice.
    captured_addr_i = '1;
    library_addr_i  = '0;
    bands_i         = 9'd1;
    library_size_i  = 9'd1;
  endtask

  task automatic go(input string name, input logic exp_err);
    launch();
    for (int c = 0; c < 2000 && n_done == 0; c++) step();
    repeat (8) step();
    check({name, "_done_once"}, n_done, 1);
    check({name, "_reqs"}, n_req, exp_addr.size());
    check({name, "_words"}, n_pop, exp_tag.size());
    check({name, "_error"}, error_o, exp_err);
    check({name, "_busy_end"}, busy_o, 0);
    check({name, "_inflight_le2"}, max_inflight <= 2, 1);
  endtask

  task automatic check_quiet(input string name);
    check({name, "_ctrl"}, {obi_req_o, data_valid_o, busy_o, done_o, error_o,
                            is_captured_o, last_pack_o, last_pixel_o}, 0);
    check({name, "_addr"}, obi_addr_o, 0);
    check({name, "_pix"}, pixel_idx_o, 0);
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; clear_i = 1'b0;
    captured_addr_i = '0; library_addr_i = '0; bands_i = '0; library_size_i = '0;
    obi_gnt_i = 1'b0; obi_rvalid_i = 1'b0; obi_rdata_i = '0; data_ready_i = 1'b0;
    gnt_mode = 0; lat_min = 0; lat_max = 0; stall_at = -1; stall_left = 0;
    watch_idx = -1; held_req = 1'b0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    check("we_const", obi_we_o, 0);
    rst = 1'b0;
    step();

    // Ten bands, two pixels, always granted, zero-latency responses.
    setup(32'h4321_8764, 32'h3242_2340, 10, 2);
    go("basic", 1'b0);
    check("basic_last_req", last_req_addr, 32'h3242_2364);
    check("basic_last_pixel_at", last_pixel_at, 14);

    // Odd band count: five packs, second pixel starts 0x14 in.
    setup(32'h0000_0100, 32'h1000_0000, 9, 3);
    watch_idx = 10;
    go("odd", 1'b0);
    check("odd_pix1_addr", watch_addr, 32'h1000_0014);
    watch_idx = -1;

    // Downstream stall of 20 cycles in the middle of the library phase.
    setup(32'h0000_2000, 32'h0000_8000, 10, 3);
    stall_at = 8;
    go("stall", 1'b0);

    // Random grant and response latency.
    setup(32'hA000_0040, 32'hB000_0800, 7, 3);
    gnt_mode = 1; lat_min = 0; lat_max = 3;
    go("rand", 1'b0);
    gnt_mode = 0; lat_max = 0;

    // Empty library: immediate done with error, no bus traffic.
    setup(32'h0000_0400, 32'h0000_0800, 4, 0);
    go("nolib", 1'b1);
    check("nolib_no_req", n_reqcyc, 0);
    setup(32'h0000_0400, 32'h0000_0800, 3, 1);
    go("after_err", 1'b0);

    // Abort during the library phase with two reads outstanding.
    setup(32'h0000_3000, 32'h0000_5000, 10, 4);
    lat_min = 3; lat_max = 3;
    begin
      logic reached;
      reached = 1'b0;
      launch();
      for (int c = 0; c < 300 && !reached; c++) begin
        step();
        if (n_req >= 7 && n_req - n_rv == 2) reached = 1'b1;
      end
      check("clr_reached", reached, 1);
    end
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    check("clr_idle", busy_o, 0);
    n_valid = 0;
    repeat (10) step();
    check("clr_no_valid", n_valid, 0);
    check("clr_no_done", n_done, 0);
    check("clr_no_req", n_reqcyc > 0 && obi_req_o, 0);
    lat_min = 0; lat_max = 0;
    setup(32'h0000_6000, 32'h0000_7000, 4, 2);
    go("after_clr", 1'b0);

    // Asynchronous reset in the middle of a job.
    setup(32'h0000_1000, 32'h0000_2000, 10, 2);
    launch();
    repeat (6) step();
    #2 rst = 1'b1;
    #1 check_quiet("midrst");
    rq_addr.delete(); rq_dly.delete(); held_req = 1'b0;
    obi_rvalid_i = 1'b0; obi_rdata_i = '0;
    n_done = 0;
    repeat (2) step();
    rst = 1'b0;
    repeat (5) step();
    check("midrst_no_done", n_done, 0);
    setup(32'h0000_1000, 32'h0000_2000, 2, 2);
    go("after_rst", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
